// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns a load/store into a fixed-latency
// memory transaction, stalls the pipeline for its duration and formats load results.
module mem_access_ctrl #(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_ld,
    input  logic              req_st,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic              misalign,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    // Undefined encodings fall through to word size.
    function automatic size_e size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return SZ_B;
            3'b001, 3'b101: return SZ_H;
            default:        return SZ_W;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [1:0]         off_q, off_d;
    logic [2:0]         f3_q, f3_d;
    logic               st_q, st_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        ld_data_q, ld_data_d;

    logic               req;
    size_e              req_size;
    logic               aligned;
    logic               last;
    logic [3:0]         req_be;
    logic [31:0]        req_wdata;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        rd_fmt;
    logic               unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];

    // A request seen while reset is held must not raise stall or misalign.
    assign req      = (req_ld | req_st) & ~RST;
    assign req_size = size_of(funct3);
    assign last     = (cnt_q == CNT_W'(1));

    always_comb begin
        aligned   = 1'b1;
        req_be    = 4'hF;
        req_wdata = wdata;
        case (req_size)
            SZ_B: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                aligned   = ~addr[0];
                req_be    = 4'b0011 << {addr[1], 1'b0};
                req_wdata = {2{wdata[15:0]}};
            end
            default: aligned = (addr[1:0] == 2'b00);
        endcase
        if (!req_st) begin
            req_be = 4'hF;
        end
    end

    always_comb begin
        rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_of(f3_q))
            SZ_B:    rd_fmt = {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
            SZ_H:    rd_fmt = {{16{~f3_q[2] & rd_half[15]}}, rd_half};
            default: rd_fmt = mem_rdata;
        endcase
    end

    // NOTE: every output and next-state value gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        off_d     = off_q;
        f3_d      = f3_q;
        st_d      = st_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        ld_data_d = ld_data_q;
        stall     = 1'b0;
        misalign  = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        ld_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        waddr_d = addr[ADDR_W+1:2];
                        off_d   = addr[1:0];
                        f3_d    = funct3;
                        st_d    = req_st;
                        wdata_d = req_wdata;
                        be_d    = req_be;
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall  = 1'b1;
                mem_cs = 1'b1;
                mem_we = st_q & last;
                cnt_d  = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d = DONE;
                    if (!st_q) begin
                        ld_data_d = rd_fmt;
                    end
                end
            end
            DONE: begin
                ld_valid = ~st_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            waddr_q   <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            st_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            waddr_q   <= waddr_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
            st_q      <= st_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign mem_be    = (state_q == BUSY) ? be_q : 4'h0;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, multi-cycle corner
// sequences and randomized accesses checked against a byte-level reference model.
module tb_mem_access_ctrl;

    localparam int LAT = 8;
    localparam int AW  = 12;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_ld, req_st;
    logic [2:0]    funct3;
    logic [31:0]   addr, wdata, mem_rdata;
    logic          stall, ld_valid, misalign, mem_cs, mem_we;
    logic [31:0]   ld_data, mem_wdata;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;

    mem_access_ctrl #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .req_ld(req_ld), .req_st(req_st), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
        .misalign(misalign), .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] ld_exp;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          we_total = 0;
    logic [31:0] held_ld = 32'h0;

    always @(negedge CLK) if (mem_we === 1'b1) we_total++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: works on byte offsets and access size in plain arithmetic.
    function automatic vec_t model(input vec_t v);
        int     sz, off;
        longint val;
        vec_t   r;
        r   = v;
        sz  = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        off = int'(v.a[1:0]);
        r.mis = ((off % sz) != 0);
        r.mwd = 32'h0;
        if (v.st) begin
            r.be = 4'(((1 << sz) - 1) << off);
            for (int b = 0; b < 4; b++) r.mwd[8*b +: 8] = v.wd[8*(b % sz) +: 8];
        end else begin
            r.be = 4'hF;
        end
        val = longint'(v.rd >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if ((v.f3 == 3'd0 || v.f3 == 3'd1) && val >= longint'(64'd1 << (8 * sz - 1)))
            val = val - longint'(64'd1 << (8 * sz));
        r.ld_exp = 32'(val);
        return r;
    endfunction

    // Drives one request from the next falling edge and observes it through DONE.
    task automatic do_access(input vec_t v, input string tag);
        int            stall_n, cs_n, we_n, we_at, lv_n, mis_n;
        logic          cs0, hold_ok, lv_last, stall_last;
        logic [3:0]    be1;
        logic [AW-1:0] a1, exp_addr;
        logic [31:0]   wd1, ldd;
        exp_addr = v.a[AW+1:2];
        @(negedge CLK);
        req_ld = v.ld; req_st = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
        mem_rdata = $urandom;
        #1;
        if (v.mis) begin
            check({tag, " misalign_pulse"}, 32'(misalign), 32'd1);
            check({tag, " misalign_stall"}, 32'(stall), 32'd0);
            check({tag, " misalign_cs"}, 32'(mem_cs), 32'd0);
            return;
        end
        stall_n = 0; cs_n = 0; we_n = 0; we_at = -1; lv_n = 0; mis_n = 0;
        hold_ok = 1'b1; cs0 = 1'b0; be1 = '0; a1 = '0; wd1 = '0;
        lv_last = 1'b0; stall_last = 1'b0; ldd = '0;
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) begin
                @(negedge CLK);
                mem_rdata = (k == LAT - 1) ? v.rd : $urandom;
                #1;
            end
            stall_n += int'(stall);
            cs_n    += int'(mem_cs);
            lv_n    += int'(ld_valid);
            mis_n   += int'(misalign);
            if (mem_we === 1'b1) begin we_n++; we_at = k; end
            if (k == 0) cs0 = mem_cs;
            if (k == 1) begin be1 = mem_be; a1 = mem_addr; wd1 = mem_wdata; end
            if (mem_cs && (mem_be !== be1 || mem_addr !== a1 || mem_wdata !== wd1)) hold_ok = 1'b0;
            if (k == LAT) begin lv_last = ld_valid; stall_last = stall; ldd = ld_data; end
        end
        check({tag, " stall_cycles"}, 32'(stall_n), 32'(LAT));
        check({tag, " stall_in_done"}, 32'(stall_last), 32'd0);
        check({tag, " cs_cycle0"}, 32'(cs0), 32'd0);
        check({tag, " cs_cycles"}, 32'(cs_n), 32'(LAT - 1));
        check({tag, " we_pulses"}, 32'(we_n), 32'(v.st));
        if (v.st) check({tag, " we_cycle"}, 32'(we_at), 32'(LAT - 1));
        check({tag, " mem_be"}, 32'(be1), 32'(v.be));
        check({tag, " mem_addr"}, 32'(a1), 32'(exp_addr));
        if (v.st) check({tag, " mem_wdata"}, wd1, v.mwd);
        check({tag, " lanes_held"}, 32'(hold_ok), 32'd1);
        check({tag, " ld_valid_cycles"}, 32'(lv_n), 32'(!v.st));
        check({tag, " ld_valid_done"}, 32'(lv_last), 32'(!v.st));
        if (!v.st) held_ld = v.ld_exp;
        check({tag, " ld_data"}, ldd, held_ld);
        check({tag, " no_misalign"}, 32'(mis_n), 32'd0);
    endtask

    task automatic idle(input int n);
        req_ld = 1'b0; req_st = 1'b0;
        repeat (n) begin
            @(negedge CLK);
            #1;
            check("idle_stall", 32'(stall), 32'd0);
            check("idle_cs", 32'(mem_cs), 32'd0);
        end
    endtask

    vec_t tbl [17];
    vec_t r;
    int   w0;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1'b0, 4'hF, 32'h0, 32'h00000080};
        tbl[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 1'b0, 4'hF, 32'h0, 32'h00008012};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h1234F00D, 1'b0, 4'hF, 32'h0, 32'hFFFFF00D};
        tbl[5]  = '{1'b0, 1'b1, 3'b001, 32'h022, 32'h0000ABCD, 32'h0, 1'b0, 4'hC, 32'hABCDABCD, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 3'b000, 32'h005, 32'h123456A5, 32'h0, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h040, 32'hCAFEF00D, 32'h0, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 3'b010, 32'h002, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 3'b011, 32'h102, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 32'h87654321, 1'b0, 4'hF, 32'h0, 32'h87654321};
        tbl[13] = '{1'b0, 1'b1, 3'b111, 32'h008, 32'h01020304, 32'h0, 1'b0, 4'hF, 32'h01020304, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 3'b000, 32'h007, 32'h000000EE, 32'h0, 1'b0, 4'h8, 32'hEEEEEEEE, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 3'b101, 32'hFFFF3FFE, 32'h0, 32'h7FFF0001, 1'b0, 4'hF, 32'h0, 32'h00007FFF};
        tbl[16] = '{1'b1, 1'b0, 3'b000, 32'h000, 32'h0, 32'h0000007F, 1'b0, 4'hF, 32'h0, 32'h0000007F};

        RST = 1'b1; req_ld = 1'b0; req_st = 1'b0; funct3 = 3'b0;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0;
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_ld_valid", 32'(ld_valid), 32'd0);
        check("reset_misalign", 32'(misalign), 32'd0);
        check("reset_cs", 32'(mem_cs), 32'd0);
        check("reset_we", 32'(mem_we), 32'd0);
        check("reset_be", 32'(mem_be), 32'd0);
        check("reset_ld_data", ld_data, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        idle(1);

        for (int i = 0; i < 17; i++) begin
            do_access(tbl[i], $sformatf("vec%0d", i));
            idle(1);
        end

        // Two stores held through DONE: back-to-back transactions.
        w0 = we_total;
        r = '{1'b0, 1'b1, 3'b010, 32'h200, 32'h11111111, 32'h0, 1'b0, 4'hF, 32'h11111111, 32'h0};
        do_access(r, "b2b_sw0");
        r = '{1'b0, 1'b1, 3'b010, 32'h204, 32'h22222222, 32'h0, 1'b0, 4'hF, 32'h22222222, 32'h0};
        do_access(r, "b2b_sw1");
        idle(1);
        check("b2b_we_total", 32'(we_total - w0), 32'd2);

        // Reset on the third BUSY cycle of a store drops the write.
        w0 = we_total;
        @(negedge CLK);
        req_st = 1'b1; req_ld = 1'b0; funct3 = 3'b010; addr = 32'h20; wdata = 32'h55AA55AA;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_mid_busy_stall", 32'(stall), 32'd1);
        check("rst_mid_busy_cs", 32'(mem_cs), 32'd1);
        #1;
        RST = 1'b1; req_st = 1'b0;
        #1;
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_cs", 32'(mem_cs), 32'd0);
        check("rst_mid_we", 32'(mem_we), 32'd0);
        check("rst_mid_ld_data", ld_data, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        held_ld = 32'h0;
        idle(3);
        check("rst_mid_no_write", 32'(we_total - w0), 32'd0);
        r = '{1'b1, 1'b0, 3'b010, 32'h010, 32'h0, 32'h0BADF00D, 1'b0, 4'hF, 32'h0, 32'h0BADF00D};
        do_access(r, "after_rst_lw");
        idle(1);

        // Randomized accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            r.ld = 1'($urandom); r.st = 1'($urandom);
            if (!r.ld && !r.st) r.ld = 1'b1;
            r.f3 = 3'($urandom);
            r.a  = $urandom; r.wd = $urandom; r.rd = $urandom;
            r = model(r);
            do_access(r, $sformatf("rand%0d", i));
            if (1'($urandom) || r.mis) idle(1);
        end
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
